psr_access_controller: RTL

- Arbitrates and sequences every write into the processor status register (PSR).
- Write sources: ALU condition-code updates, explicit PSR writes (wr %psr), trap entry, and trap return (rett).
- Drives the PSR's rw/flags/displacement inputs and owns the trap-enable bit and the saved-PSR shadow.
- Sits between the control unit and the PSR; stalls the pipeline during multi-cycle sequences.

---
 rtl/psr_access_controller.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/psr_access_controller.sv
// Arbitrates and sequences every write into the processor status register:
// ALU condition codes, explicit writes, trap entry and trap return.
module psr_access_controller #(
   parameter int              NIRQ       = 4,
   parameter int              AW         = 32,
   parameter logic [AW-1:0]   VEC_BASE   = 'h0000_0800,
   parameter int              VEC_STRIDE = 16
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            cc_req,
   input  logic [3:0]      cc_flags,
   output logic            cc_ack,
   input  logic            wr_req,
   input  logic [4:0]      wr_data,
   output logic            wr_ack,
   input  logic            rett_req,
   output logic            rett_err,
   input  logic [NIRQ-1:0] irq_req,
   input  logic [4:0]      psr_status,
   output logic            psr_rw,
   output logic [3:0]      psr_flags,
   output logic            psr_disp,
   output logic            et,
   output logic [4:0]      saved_psr,
   output logic            stall,
   output logic            vec_valid,
   output logic [AW-1:0]   trap_vec,
   input  logic            vec_ack
);

   localparam int IW = (NIRQ > 1) ? $clog2(NIRQ) : 1;

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_WR2    = 2'd1;
   localparam logic [1:0] S_SAVE   = 2'd2;
   localparam logic [1:0] S_VECTOR = 2'd3;

   logic [1:0]    state_q, state_d;
   logic          et_q, et_d;
   logic [4:0]    saved_q, saved_d;
   logic [IW-1:0] idx_q, idx_d;
   logic          rw_q, rw_d;
   logic [3:0]    flags_q, flags_d;
   logic          disp_q, disp_d;
   logic          cc_ack_q, cc_ack_d;
   logic          wr_ack_q, wr_ack_d;
   logic          rett_err_q, rett_err_d;
   logic          wr2_ack_q, wr2_ack_d;
   logic [IW-1:0] irq_idx;

   // Lowest set index wins: scanning downward lets lower indices overwrite.
   always_comb begin
      irq_idx = '0;
      for (int i = NIRQ - 1; i >= 0; i--) begin
         if (irq_req[i]) irq_idx = IW'(i);
      end
   end

   always_comb begin
      // NOTE: every next-state signal gets a default first so no latch is inferred.
      state_d    = state_q;
      et_d       = et_q;
      saved_d    = saved_q;
      idx_d      = idx_q;
      rw_d       = 1'b0;
      flags_d    = flags_q;
      disp_d     = 1'b0;
      cc_ack_d   = 1'b0;
      wr_ack_d   = 1'b0;
      rett_err_d = 1'b0;
      wr2_ack_d  = wr2_ack_q;

      case (state_q)
         S_IDLE: begin
            if (et_q && (|irq_req)) begin
               idx_d   = irq_idx;
               state_d = S_SAVE;
            end else if (rett_req) begin
               if (et_q) begin
                  rett_err_d = 1'b1;
               end else begin
                  rw_d    = 1'b1;
                  flags_d = saved_q[3:0];
                  et_d    = 1'b1;
                  if (saved_q[4]) begin
                     state_d   = S_WR2;
                     wr2_ack_d = 1'b0;
                  end
               end
            end else if (wr_req) begin
               rw_d    = 1'b1;
               flags_d = wr_data[3:0];
               if (wr_data[4]) begin
                  state_d   = S_WR2;
                  wr2_ack_d = 1'b1;
               end else begin
                  wr_ack_d = 1'b1;
               end
            end else if (cc_req) begin
               rw_d     = 1'b1;
               flags_d  = cc_flags;
               cc_ack_d = 1'b1;
            end
         end
         // Second strobe only sets the displacement bit; flags are don't-care.
         S_WR2: begin
            rw_d     = 1'b1;
            disp_d   = 1'b1;
            wr_ack_d = wr2_ack_q;
            state_d  = S_IDLE;
         end
         S_SAVE: begin
            saved_d = psr_status;
            et_d    = 1'b0;
            state_d = S_VECTOR;
         end
         S_VECTOR: begin
            if (vec_ack) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_IDLE;
         et_q       <= 1'b1;
         saved_q    <= '0;
         idx_q      <= '0;
         rw_q       <= 1'b0;
         flags_q    <= '0;
         disp_q     <= 1'b0;
         cc_ack_q   <= 1'b0;
         wr_ack_q   <= 1'b0;
         rett_err_q <= 1'b0;
         wr2_ack_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         et_q       <= et_d;
         saved_q    <= saved_d;
         idx_q      <= idx_d;
         rw_q       <= rw_d;
         flags_q    <= flags_d;
         disp_q     <= disp_d;
         cc_ack_q   <= cc_ack_d;
         wr_ack_q   <= wr_ack_d;
         rett_err_q <= rett_err_d;
         wr2_ack_q  <= wr2_ack_d;
      end
   end

   assign psr_rw    = rw_q;
   assign psr_flags = flags_q;
   assign psr_disp  = disp_q;
   assign et        = et_q;
   assign saved_psr = saved_q;
   assign cc_ack    = cc_ack_q;
   assign wr_ack    = wr_ack_q;
   assign rett_err  = rett_err_q;
   assign stall     = (state_q != S_IDLE);
   assign vec_valid = (state_q == S_VECTOR);
   assign trap_vec  = vec_valid ? (VEC_BASE + AW'(idx_q) * AW'(VEC_STRIDE)) : '0;

endmodule
